// File: rtl/l2_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : l2_fifo_arb
// Purpose  : Round-robin write arbiter, valid/ready read drain and clear
//            sequencer for the 32x32 L2 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module l2_fifo_arb #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sw_clr,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          fifo_wr,
   output logic [DW-1:0] fifo_din,
   input  logic          fifo_full,
   output logic          fifo_rd,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_clr,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic [CW-1:0] wr_cnt0,
   output logic [CW-1:0] wr_cnt1
);

   localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_VALID = 1'b1
   } rd_state_t;

   rd_state_t     r_state;
   logic          r_m_valid;
   logic          r_clr_q;
   logic          r_last;
   logic [CW-1:0] r_cnt0;
   logic [CW-1:0] r_cnt1;

   logic          w_blk;
   logic          w_grant;
   logic          w_wr_ok;

   // Strobes are held off both on the request cycle and the clear cycle.
   assign w_blk = sw_clr | r_clr_q;

   always_comb begin
      w_grant = ~r_last;
      if (req0_valid & ~req1_valid) begin
         w_grant = 1'b0;
      end else if (req1_valid & ~req0_valid) begin
         w_grant = 1'b1;
      end
   end

   assign w_wr_ok    = ~fifo_full & ~w_blk;
   assign fifo_wr    = (req0_valid | req1_valid) & w_wr_ok;
   assign req0_ready = ~w_grant & w_wr_ok;
   assign req1_ready = w_grant & w_wr_ok;
   assign fifo_din   = w_grant ? req1_data : req0_data;

   assign fifo_rd  = ~fifo_empty & ~w_blk & ((r_state == ST_EMPTY) | m_ready);
   assign fifo_clr = r_clr_q;
   assign m_valid  = r_m_valid;
   assign m_data   = fifo_dout;
   assign wr_cnt0  = r_cnt0;
   assign wr_cnt1  = r_cnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_q <= 1'b0;
      end else begin
         r_clr_q <= sw_clr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (r_clr_q) begin
         r_last <= 1'b1;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (fifo_wr) begin
         r_last <= w_grant;
         if (w_grant) begin
            r_cnt1 <= r_cnt1 + c_cnt_one;
         end else begin
            r_cnt0 <= r_cnt0 + c_cnt_one;
         end
      end
   end

   // m_data is the FIFO's registered output, so the state only tracks
   // whether that register currently holds an unconsumed word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_EMPTY;
         r_m_valid <= 1'b0;
      end else if (r_clr_q) begin
         r_state   <= ST_EMPTY;
         r_m_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (fifo_rd) begin
                  r_state   <= ST_VALID;
                  r_m_valid <= 1'b1;
               end
            end
            ST_VALID: begin
               if (m_ready & ~fifo_rd) begin
                  r_state   <= ST_EMPTY;
                  r_m_valid <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_EMPTY;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_fifo_arb
// Purpose  : Directed bench for l2_fifo_arb with a behavioural 32x32 FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_fifo_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sw_clr = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req1_valid = 1'b0;
   logic [31:0] req0_data = '0;
   logic [31:0] req1_data = '0;
   logic        m_ready = 1'b0;

   logic        req0_ready, req1_ready, fifo_wr, fifo_rd, fifo_clr, m_valid;
   logic [31:0] fifo_din, m_data;
   logic [15:0] wr_cnt0, wr_cnt1;

   logic        b_req0_ready, b_req1_ready, b_fifo_wr, b_fifo_rd, b_fifo_clr, b_m_valid;
   logic [31:0] b_fifo_din, b_m_data;
   logic [3:0]  b_wr_cnt0, b_wr_cnt1;

   logic [31:0] mem [32];
   int          fcnt, wp, rp;
   logic [31:0] fifo_dout;
   logic        fifo_full, fifo_empty;

   logic [31:0] got[$];
   int          rd_strobes = 0;
   int          acc1 = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   l2_fifo_arb #(.DW(32), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .sw_clr(sw_clr),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_clr(fifo_clr), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
   );

   l2_fifo_arb #(.DW(32), .CW(4)) u_dut_cw4 (
      .clk(clk), .rst_n(rst_n), .sw_clr(sw_clr),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_req1_ready),
      .fifo_wr(b_fifo_wr), .fifo_din(b_fifo_din), .fifo_full(fifo_full),
      .fifo_rd(b_fifo_rd), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_clr(b_fifo_clr), .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(m_ready),
      .wr_cnt0(b_wr_cnt0), .wr_cnt1(b_wr_cnt1)
   );

   // Behavioural FIFO: registered read port, synchronous clear.
   assign fifo_full  = (fcnt == 32);
   assign fifo_empty = (fcnt == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= 0; wp <= 0; rp <= 0; fifo_dout <= '0;
      end else if (fifo_clr) begin
         fcnt <= 0; wp <= 0; rp <= 0;
      end else begin
         if (fifo_wr && !fifo_full) begin
            mem[wp] <= fifo_din;
            wp <= (wp + 1) % 32;
         end
         if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rp];
            rp <= (rp + 1) % 32;
         end
         fcnt <= fcnt + ((fifo_wr && !fifo_full) ? 1 : 0) - ((fifo_rd && !fifo_empty) ? 1 : 0);
      end
   end

   always @(posedge clk) begin
      if (rst_n && m_valid && m_ready) got.push_back(m_data);
      if (rst_n && fifo_rd) rd_strobes <= rd_strobes + 1;
      if (rst_n && req1_valid && req1_ready) acc1 <= acc1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_got(input int n, input string tag);
      int k = 0;
      while (got.size() < n && k < 200) begin
         cyc();
         k++;
      end
      chk(tag, 32'(got.size()), 32'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, a1, bad, rs0;

      // Reset values
      repeat (3) @(posedge clk);
      #2;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_fifo_clr", 32'(fifo_clr), 32'd0);
      chk("rst_cnt", {wr_cnt1, wr_cnt0}, 32'd0);
      chk("rst_strobes", {30'd0, fifo_wr, fifo_rd}, 32'd0);
      rst_n = 1'b1;

      // Single write from req0
      cyc();
      m_ready = 1'b1; req0_valid = 1'b1; req0_data = 32'hA5A5_0001;
      #1;
      chk("single_wr", {30'd0, fifo_wr, req0_ready}, 32'd3);
      chk("single_din", fifo_din, 32'hA5A5_0001);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("single_rd", {30'd0, fifo_rd, m_valid}, 32'd2);
      chk("single_cnt0", 32'(wr_cnt0), 32'd1);
      cyc();
      #1;
      chk("single_m_valid", 32'(m_valid), 32'd1);
      chk("single_m_data", m_data, 32'hA5A5_0001);
      chk("single_no_rd", 32'(fifo_rd), 32'd0);

      // Clear so the round-robin starts from a known last=1
      cyc(); sw_clr = 1'b1;
      cyc(); sw_clr = 1'b0;
      cyc(); #1;
      chk("pre_rr_cnt", {wr_cnt1, wr_cnt0}, 32'd0);

      // Round-robin with both producers valid
      base = got.size();
      for (int i = 0; i < 6; i++) begin
         cyc();
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_data = 32'h100 + 32'((i + 1) / 2);
         req1_data = 32'h200 + 32'(i / 2);
         #1;
         chk("rr_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("rr_din", fifo_din, (i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2));
      end
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_got(base + 6, "rr_drain");
      chk("rr_cnt", {wr_cnt1, wr_cnt0}, {16'd3, 16'd3});
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         if (got.size() <= base + k) bad++;
         else if (got[base + k] !== ((k % 2 == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2))) bad++;
      end
      chk("rr_order", 32'(bad), 32'd0);

      // Full backpressure: 33 taken (32 in FIFO plus one parked on m_data)
      cyc();
      m_ready = 1'b0;
      base = got.size();
      a1 = acc1;
      for (int i = 0; i < 34; i++) begin
         if (i > 0) cyc();
         req1_valid = 1'b1;
         req1_data = 32'h300 + 32'(acc1 - a1);
         #1;
         if (i == 32) chk("full_last_ok", 32'(req1_ready), 32'd1);
         if (i == 33) chk("full_blocked", {30'd0, fifo_full, req1_ready}, 32'd2);
      end
      cyc();
      req1_valid = 1'b0;
      chk("full_accepted", 32'(acc1 - a1), 32'd33);
      m_ready = 1'b1;
      wait_got(base + 33, "full_drain");
      repeat (3) cyc();
      chk("full_no_dup", 32'(got.size()), 32'(base + 33));
      bad = 0;
      for (int k = 0; k < 33; k++) begin
         if (got.size() <= base + k) bad++;
         else if (got[base + k] !== 32'h300 + 32'(k)) bad++;
      end
      chk("full_order", 32'(bad), 32'd0);

      // Consumer stall with 4 words queued
      m_ready = 1'b0;
      base = got.size();
      rs0 = rd_strobes;
      for (int k = 0; k < 4; k++) begin
         cyc();
         req0_valid = 1'b1; req0_data = 32'h400 + 32'(k);
         #1;
         chk("stall_wr", 32'(req0_ready), 32'd1);
      end
      cyc(); req0_valid = 1'b0;
      m_ready = 1'b1; #1;
      chk("stall_s0", {m_data[30:0], fifo_rd}, {31'h400, 1'b1});
      cyc(); m_ready = 1'b0; #1;
      chk("stall_s1", {m_data[30:0], fifo_rd}, {31'h401, 1'b0});
      cyc(); m_ready = 1'b0; #1;
      chk("stall_s2", {m_data[30:0], fifo_rd}, {31'h401, 1'b0});
      cyc(); m_ready = 1'b1; #1;
      chk("stall_s3", {m_data[30:0], fifo_rd}, {31'h401, 1'b1});
      wait_got(base + 4, "stall_drain");
      repeat (2) cyc();
      chk("stall_rd_count", 32'(rd_strobes - rs0), 32'd4);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         if (got.size() <= base + k) bad++;
         else if (got[base + k] !== 32'h400 + 32'(k)) bad++;
      end
      chk("stall_order", 32'(bad), 32'd0);

      // Clear mid-burst with 10 words queued
      m_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         req0_valid = 1'b1; req0_data = 32'h500 + 32'(k);
      end
      cyc(); req0_valid = 1'b0;
      cyc(); #1;
      chk("clr_pre_valid", 32'(m_valid), 32'd1);
      base = got.size();
      cyc();
      sw_clr = 1'b1; m_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 32'h600; req1_data = 32'h700;
      #1;
      chk("clr_t0", {27'd0, fifo_clr, req0_ready, req1_ready, fifo_wr, fifo_rd}, 32'd0);
      cyc();
      sw_clr = 1'b0;
      #1;
      chk("clr_t1", {26'd0, m_valid, fifo_clr, req0_ready, req1_ready, fifo_wr, fifo_rd}, 32'h10);
      cyc(); #1;
      chk("clr_t2_cnt", {wr_cnt1, wr_cnt0}, 32'd0);
      chk("clr_t2_ctl", {28'd0, m_valid, fifo_clr, fifo_rd, fifo_empty}, 32'd1);
      chk("clr_t2_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      chk("clr_t2_din", fifo_din, 32'h600);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_got(base + 2, "clr_after");
      chk("clr_next_word", (got.size() > 0) ? got[got.size() - 1] : 32'hDEAD, 32'h600);

      // Counter wrap on the 4-bit instance: 17 req0 writes since the clear
      for (int k = 0; k < 16; k++) begin
         cyc();
         req0_valid = 1'b1; req0_data = 32'h900 + 32'(k);
      end
      cyc(); req0_valid = 1'b0;
      cyc(); #1;
      chk("wrap_cnt16", 32'(wr_cnt0), 32'd17);
      chk("wrap_cnt4", 32'(b_wr_cnt0), 32'd1);
      wait_got(base + 18, "wrap_drain");

      // Asynchronous reset mid-operation
      m_ready = 1'b0;
      cyc(); req1_valid = 1'b1; req1_data = 32'h800;
      cyc(); req1_valid = 1'b0;
      cyc(); cyc(); #1;
      chk("mid_pre", {30'd0, m_valid, wr_cnt1[0]}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {m_valid, fifo_clr, fifo_rd, 13'd0, wr_cnt0}, 32'd0);
      chk("mid_rst_cnt1", 32'(wr_cnt1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
